// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and sizes for the round-robin mux arbiter
package arb_pkg;
  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] req_idx_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;
endpackage

// File: rtl/mux_4_1.sv
// rtl/mux_4_1.sv - plain 4:1 data selector
module mux_4_1 #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end
endmodule

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - picks the first set request bit at or after ptr (mod 4)
module rr_pick4
  import arb_pkg::*;
(
  input  logic [3:0] req,
  input  req_idx_t   ptr,
  output req_idx_t   gnt,
  output logic       any
);
  req_idx_t idx;

  // Scan from farthest to nearest so the nearest set bit is written last.
  always_comb begin
    gnt = ptr;
    idx = ptr;
    any = |req;
    for (int j = 3; j >= 0; j--) begin
      idx = ptr + req_idx_t'(j);
      if (req[idx]) gnt = idx;
    end
  end
endmodule

// File: rtl/rr_mux_arbiter_4.sv
// rtl/rr_mux_arbiter_4.sv - round-robin burst arbiter sharing one registered 4:1 mux
module rr_mux_arbiter_4
  import arb_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_src,
  input  logic               out_ready
);
  localparam logic [3:0] BURST_M1 = 4'(BURST - 1);

  lock_state_e      state, state_n;
  req_idx_t         ptr, ptr_n;
  req_idx_t         owner, owner_n;
  logic [3:0]       cnt, cnt_n;

  req_idx_t         pick_gnt;
  req_idx_t         gnt;
  logic             any_req;
  logic             owner_valid;
  logic             load;
  logic             accept;
  logic [WIDTH-1:0] sel_data;

  rr_pick4 u_pick (
    .req (in_valid),
    .ptr (ptr),
    .gnt (pick_gnt),
    .any (any_req)
  );

  assign owner_valid = in_valid[owner];
  assign gnt         = (state == LOCKED && owner_valid) ? owner : pick_gnt;
  assign load        = !out_valid || out_ready;
  assign accept      = load && any_req && rst_n;
  assign in_ready    = accept ? (4'b0001 << gnt) : 4'b0000;

  mux_4_1 #(.WIDTH(WIDTH)) u_mux (
    .d0  (in_data[0*WIDTH +: WIDTH]),
    .d1  (in_data[1*WIDTH +: WIDTH]),
    .d2  (in_data[2*WIDTH +: WIDTH]),
    .d3  (in_data[3*WIDTH +: WIDTH]),
    .sel (gnt),
    .y   (sel_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= UNLOCKED;
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      owner <= owner_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    cnt_n   = cnt;
    case (state)
      UNLOCKED: begin
        if (accept) begin
          if (BURST > 1) begin
            state_n = LOCKED;
            owner_n = gnt;
            cnt_n   = BURST_M1;
          end else begin
            ptr_n = gnt + req_idx_t'(1);
          end
        end
      end
      LOCKED: begin
        // Backpressure (load=0) freezes the lock entirely.
        if (load) begin
          if (owner_valid) begin
            cnt_n = cnt - 4'd1;
            if (cnt == 4'd1) begin
              state_n = UNLOCKED;
              ptr_n   = owner + req_idx_t'(1);
            end
          end else begin
            ptr_n   = owner + req_idx_t'(1);
            state_n = UNLOCKED;
            if (accept && BURST > 1) begin
              state_n = LOCKED;
              owner_n = gnt;
              cnt_n   = BURST_M1;
            end
          end
        end
      end
      default: state_n = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (load) begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_src   <= gnt;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
